// File: rtl/seq_divider_6bit.sv
// Sequential restoring divider: one quotient bit per cycle, MSB first.
// Results and status are registered and only change when the FSM enters DONE.
module seq_divider_6bit #(
  parameter int N = 6
) (
  input  logic         Clock,
  input  logic         Reset_n,
  input  logic         Start,
  input  logic [N-1:0] Dividend,
  input  logic [N-1:0] Divisor,
  output logic         Busy,
  output logic         Done,
  output logic         Div_By_Zero,
  output logic [N-1:0] Quotient,
  output logic [N-1:0] Remainder
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e         state_q, state_d;
  logic [N-1:0]   dvd_q, dvd_d;
  logic [N-1:0]   dvs_q, dvs_d;
  logic [N-1:0]   prem_q, prem_d;
  logic [N-1:0]   quo_q, quo_d;
  logic [N-1:0]   rem_q, rem_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           dbz_q, dbz_d;

  logic [N:0]     shifted;
  logic [N:0]     trial;
  logic           fits;

  always_comb begin
    shifted = {prem_q, dvd_q[N-1]};
    // prem < divisor keeps shifted below 2*divisor, so bit N of the
    // (N+1)-bit difference is set exactly when the subtract goes negative.
    trial   = shifted - {1'b0, dvs_q};
    fits    = ~trial[N];

    state_d = state_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    prem_d  = prem_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    dbz_d   = dbz_q;

    case (state_q)
      CALC: begin
        prem_d = fits ? trial[N-1:0] : shifted[N-1:0];
        dvd_d  = {dvd_q[N-2:0], fits};
        if (cnt_q == '0) begin
          state_d = DONE;
          quo_d   = dvd_d;
          rem_d   = prem_d;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        if (Start) begin
          dvd_d  = Dividend;
          dvs_d  = Divisor;
          prem_d = '0;
          cnt_d  = CW'(N - 1);
          if (Divisor == '0) begin
            state_d = DONE;
            quo_d   = '1;
            rem_d   = Dividend;
            dbz_d   = 1'b1;
          end else begin
            state_d = CALC;
            dbz_d   = 1'b0;
          end
        end else begin
          state_d = IDLE;
        end
      end
    endcase

    busy_d = (state_d == CALC);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      dvd_q   <= '0;
      dvs_q   <= '0;
      prem_q  <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      prem_q  <= prem_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
    end
  end

  assign Busy        = busy_q;
  assign Done        = done_q;
  assign Div_By_Zero = dbz_q;
  assign Quotient    = quo_q;
  assign Remainder   = rem_q;

endmodule

// File: tb/tb_seq_divider_6bit.sv
// Scoreboard bench for seq_divider_6bit: directed vectors plus a full operand sweep;
// a negedge monitor pops expectations whenever Done pulses.
module tb_seq_divider_6bit;
  localparam int N = 6;

  logic         Clock = 1'b0;
  logic         Reset_n = 1'b1;
  logic         Start = 1'b0;
  logic [N-1:0] Dividend = '0;
  logic [N-1:0] Divisor = '0;
  logic         Busy, Done, Div_By_Zero;
  logic [N-1:0] Quotient, Remainder;

  seq_divider_6bit #(.N(N)) dut (
    .Clock(Clock), .Reset_n(Reset_n), .Start(Start),
    .Dividend(Dividend), .Divisor(Divisor),
    .Busy(Busy), .Done(Done), .Div_By_Zero(Div_By_Zero),
    .Quotient(Quotient), .Remainder(Remainder)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    int q; int r; int dbz; int lat; int busy; int t;
  } exp_t;

  exp_t sb[$];
  exp_t em;
  int errors = 0, checks = 0, cyc = 0;
  int busy_cnt = 0, last_q = 0, last_r = 0;

  always @(posedge Clock) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: latency is counted in edges from the accepting edge to the
  // edge at which Done is first sampled high.
  always @(negedge Clock) begin
    if (!Reset_n) begin
      busy_cnt = 0; last_q = 0; last_r = 0;
    end else if (Done) begin
      chk("done_has_expect", int'(sb.size() > 0), 1);
      if (sb.size() > 0) begin
        em = sb.pop_front();
        chk("quotient", int'(Quotient), em.q);
        chk("remainder", int'(Remainder), em.r);
        chk("div_by_zero", int'(Div_By_Zero), em.dbz);
        chk("latency", cyc - em.t + 1, em.lat);
        chk("busy_cycles", busy_cnt, em.busy);
      end
      busy_cnt = 0;
      last_q = int'(Quotient);
      last_r = int'(Remainder);
    end else begin
      if (Busy) busy_cnt++;
      chk("result_hold", int'({Quotient, Remainder}), (last_q << N) | last_r);
    end
  end

  task automatic push_exp(input int dv, input int q, input int r, input int dbz);
    exp_t e;
    e.q = q; e.r = r; e.dbz = dbz;
    e.lat  = (dv == 0) ? 1 : N + 1;
    e.busy = (dv == 0) ? 0 : N;
    e.t    = cyc + 1;
    sb.push_back(e);
  endtask

  // Inputs are scrambled right after acceptance so a design that keeps
  // reading the ports instead of its captured copies gets caught.
  task automatic issue(input int dd, input int dv, input int q, input int r, input int dbz);
    @(negedge Clock);
    Start = 1'b1; Dividend = N'(dd); Divisor = N'(dv);
    push_exp(dv, q, r, dbz);
    @(negedge Clock);
    Start = 1'b0; Dividend = N'($urandom); Divisor = N'($urandom);
  endtask

  task automatic drain();
    int k = 0;
    while (sb.size() != 0 && k < 50) begin
      @(negedge Clock);
      k++;
    end
    chk("drain_timeout", sb.size(), 0);
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_busy"}, int'(Busy), 0);
    chk({tag, "_done"}, int'(Done), 0);
    chk({tag, "_dbz"}, int'(Div_By_Zero), 0);
    chk({tag, "_quo"}, int'(Quotient), 0);
    chk({tag, "_rem"}, int'(Remainder), 0);
  endtask

  initial begin
    #1 Reset_n = 1'b0;
    #1 chk_zero_outputs("reset");
    repeat (2) @(negedge Clock);
    Reset_n = 1'b1;

    issue(45, 7, 6, 3, 0);   drain();
    issue(63, 1, 63, 0, 0);  drain();
    issue(5, 9, 0, 5, 0);    drain();
    issue(20, 0, 63, 20, 1); drain();
    issue(0, 5, 0, 0, 0);    drain();

    // Start during CALC is ignored; Start in the DONE cycle is taken.
    issue(45, 7, 6, 3, 0);
    @(negedge Clock);
    Start = 1'b1; Dividend = 6'd10; Divisor = 6'd3;
    @(negedge Clock);
    Start = 1'b0;
    begin
      int k = 0;
      while (!Done && k < 20) begin
        @(negedge Clock);
        k++;
      end
    end
    chk("wait_done", int'(Done), 1);
    Start = 1'b1; Dividend = 6'd10; Divisor = 6'd3;
    push_exp(3, 3, 1, 0);
    @(negedge Clock);
    Start = 1'b0; Dividend = N'($urandom); Divisor = N'($urandom);
    drain();

    // Abort at the third CALC cycle.
    issue(45, 7, 6, 3, 0);
    repeat (2) @(negedge Clock);
    Reset_n = 1'b0;
    #1 chk_zero_outputs("abort");
    sb.delete();
    repeat (3) @(negedge Clock);
    Reset_n = 1'b1;
    issue(12, 4, 3, 0, 0);   drain();

    for (int a = 0; a < 64; a++) begin
      for (int b = 0; b < 64; b++) begin
        if (b == 0) issue(a, b, 63, a, 1);
        else        issue(a, b, a / b, a % b, 0);
        drain();
      end
    end

    repeat (2) @(negedge Clock);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule

// File: doc/seq_divider_6bit.md
SEQ_DIVIDER_6BIT -- requirements
Module: seq_divider_6bit

Interface
REQ-001 The block SHALL have parameter N, default 6, setting the operand/result width in bits.
REQ-002 The block SHALL have port Clock, input, 1 bit, the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port Reset_n, input, 1 bit, the reset, asynchronous and active-low.
REQ-004 The block SHALL have port Start, input, 1 bit, a request to begin a division, sampled on the Clock edge.
REQ-005 The block SHALL have port Dividend, input, N bits, the unsigned dividend, captured when Start is accepted.
REQ-006 The block SHALL have port Divisor, input, N bits, the unsigned divisor, captured when Start is accepted.
REQ-007 The block SHALL have port Busy, output, 1 bit, high while a division is in progress.
REQ-008 The block SHALL have port Done, output, 1 bit, a one-cycle pulse marking valid results.
REQ-009 The block SHALL have port Div_By_Zero, output, 1 bit, set when the captured Divisor was 0.
REQ-010 The block SHALL have port Quotient, output, N bits, the unsigned quotient.
REQ-011 The block SHALL have port Remainder, output, N bits, the unsigned remainder.

Function
REQ-012 The block SHALL implement an FSM with states IDLE, CALC and DONE, each output a registered value.
REQ-013 Start SHALL be accepted only in IDLE or DONE; Start in CALC SHALL be ignored, with no effect on the operation in progress.
REQ-014 On acceptance, the block SHALL capture Dividend and Divisor into internal registers, clear the partial remainder, clear Div_By_Zero, and load an iteration counter with N-1.
REQ-015 On acceptance with Divisor != 0, the FSM SHALL enter CALC; Busy SHALL be 1 in CALC and 0 otherwise.
REQ-016 The block SHALL perform one restoring shift-subtract step per CALC cycle, MSB first:
  - shift the partial remainder left by one and bring in the next dividend bit;
  - trial-subtract the divisor using an (N+1)-bit subtract;
  - if the result is non-negative, keep the difference and set the quotient bit to 1;
  - otherwise restore the remainder and set the quotient bit to 0.
REQ-017 After exactly N CALC cycles (counter reaching 0), the FSM SHALL enter DONE.
REQ-018 With Start accepted at edge t, Done SHALL be 1 in the cycle following edge t+N+1, giving a latency of N+1 edges.
REQ-019 In DONE, Done SHALL be 1 for exactly one cycle; the FSM SHALL then go to IDLE, or to CALC if Start is accepted in DONE.
REQ-020 Quotient and Remainder SHALL update only on entry to DONE and SHALL hold their values until the next DONE or reset; intermediate values SHALL never appear on them.
REQ-021 On acceptance with Divisor == 0, the FSM SHALL go directly to DONE, with Done at edge t+1.
REQ-022 In the divide-by-zero case, the block SHALL output Quotient = all ones (2^N-1), Remainder = Dividend and Div_By_Zero = 1.
REQ-023 Div_By_Zero SHALL hold its value until the next accepted Start.
REQ-024 Results SHALL satisfy Dividend = Quotient*Divisor + Remainder with Remainder < Divisor, for all nonzero divisors.
REQ-025 Changes on the Dividend or Divisor inputs after acceptance SHALL NOT affect the result.

Reset
REQ-026 Reset_n low SHALL force, asynchronously, state IDLE, Busy=0, Done=0, Div_By_Zero=0, Quotient=0, Remainder=0, and clear the counter and internal registers.
REQ-027 Reset asserted mid-CALC SHALL abort the operation with no Done pulse.
REQ-028 After Reset_n deasserts, the first Start SHALL be accepted normally.

Verification
REQ-029 Dividend=45, Divisor=7, Start pulse -> Busy for 6 cycles, Done at edge t+7, Quotient=6, Remainder=3, Div_By_Zero=0.
REQ-030 Dividend=63, Divisor=1 -> Quotient=63, Remainder=0; and Dividend=5, Divisor=9 -> Quotient=0, Remainder=5.
REQ-031 Dividend=20, Divisor=0 -> Done at edge t+1, Quotient=63, Remainder=20, Div_By_Zero=1, Busy never 1.
REQ-032 Start re-pulsed with 10/3 during CALC of 45/7 -> ignored, result 6 r 3; then Start in the DONE cycle with 10/3 -> accepted, next result 3 r 1.
REQ-033 Reset_n low at the 3rd CALC cycle -> all outputs 0 immediately, no Done pulse; then 12/4 -> Quotient=3, Remainder=0.
REQ-034 The bench SHALL run an exhaustive 64x64 operand sweep against a reference model -> every result matches REQ-024 and REQ-022, with Done latency per REQ-018 or REQ-021.
